ox_infer_seq: RTL and testbench
===============================

# ox_infer_seq

Submit-driven inference/learning sequencer between the input manager and the O/X MLP classifier. It freezes the accumulated 16-bit input-flag vector on a submit press and presents it to the MLP. It waits a fixed settle interval, then latches the classification result for the LED/LCD stages. While a result is shown, it accepts an O or X label press and issues a single-cycle learn strobe to the MLP, with saturating statistics counters.

## Interface
- SETTLE_CYC, 4, cycles allowed for the MLP output to settle after `nn_x` or `nn_learn` changes (≥1)
- HOLD_CYC, 50_000_000, cycles a result stays valid without further input (1 s at 50 MHz; ≥1)
- CNT_W, 8, width of the statistics counters
- clk  in  1  system clock, 50 MHz
- rst  in  1  reset, asynchronous, active-low
- x_in  in  16  combined input flags from the input manager
- btn_submit  in  1  submit button level
- btn_label_o  in  1  "this was an O" label button level
- btn_label_x  in  1  "this was an X" label button level
- nn_y  in  1  MLP decision (1 = O)
- nn_o_prob_pct  in  7  MLP O-probability, 0–100
- nn_x  out  16  frozen input vector driven to the MLP
- nn_learn  out  1  learn strobe to the MLP, exactly one cycle wide
- nn_is_O  out  1  label accompanying `nn_learn`
- result_valid  out  1  result registers hold a current classification
- result_y  out  1  latched decision
- result_pct  out  7  latched probability
- busy  out  1  high in SETTLE, LEARN and COOL
- infer_count  out  CNT_W  saturating count of completed inferences
- learn_count  out  CNT_W  saturating count of learn strobes
- correct_count  out  CNT_W  saturating count of learns where `result_y` matched the label

## Operation
- Rising edges of `btn_submit`, `btn_label_o` and `btn_label_x` are detected internally. Previous-value registers update every cycle in every state. Edges arriving in states that do not accept them are dropped, not queued.
- States:
  - IDLE: no result valid. On a submit edge: `nn_x <= x_in`, `cnt <= SETTLE_CYC-1`, go to SETTLE.
  - SETTLE: count `cnt` down. At `cnt == 0`: latch `result_y`/`result_pct` from `nn_y`/`nn_o_prob_pct`, set `result_valid`, increment `infer_count`, `cnt <= HOLD_CYC-1`, go to SHOW.
  - SHOW: decrement `cnt`. Priority within a cycle: submit edge > label edge > timeout.
    - Submit edge: re-latch `nn_x <= x_in`, clear `result_valid`, go to SETTLE.
    - Exactly one label edge: `nn_is_O <= (label == O)`, `nn_learn <= 1`, increment `learn_count`, and increment `correct_count` if `result_y == nn_is_O` label. Go to LEARN.
    - Both label edges in the same cycle: ignored, counter keeps running.
    - `cnt == 0`: clear `result_valid`, go to IDLE.
  - LEARN: one cycle. `nn_learn <= 0`, `cnt <= SETTLE_CYC-1`, go to COOL. `result_valid` stays high, holding the pre-learn values.
  - COOL: count down. At 0: re-latch the result (post-learn output), `cnt <= HOLD_CYC-1`, go to SHOW. `infer_count` is not incremented.
- `nn_x` changes only on an accepted submit. `nn_is_O` holds its last label.
- Counters saturate at 2^CNT_W−1.
- `busy` is combinational from state.
- Reset (asynchronous, any state including mid-SETTLE or LEARN) forces IDLE:
  - all outputs 0, `nn_learn` 0 immediately
  - edge-detect registers 0, so a button held through reset release produces one edge

## Timing
- Submit edge sampled at cycle t:
  - `nn_x` updated and `busy` high from t+1
  - `result_valid` high at t+1+SETTLE_CYC
  - `busy` low at the same cycle
- Label edge sampled at t in SHOW:
  - `nn_learn` high during t+1 only
  - result re-latched, visible at t+2+SETTLE_CYC
- With no input in SHOW, `result_valid` drops exactly HOLD_CYC cycles after it rose.
- No pipelining: one transaction in flight.

## Structure
- Package `ox_pkg`:
  - state encoding: IDLE, SETTLE, SHOW, LEARN, COOL
  - `OX_X_W = 16`, `OX_PCT_W = 7`
  - default settle and hold constants
- Sub-module `edge_det`: rising-edge detector with async active-low reset, instantiated three times.
- `cnt` is a single down-counter sized by `$clog2(HOLD_CYC)`, shared across states.

## Test plan
- Reset, then submit with `x_in = 16'hF99F`, `nn_y = 1`, `nn_o_prob_pct = 92` → `nn_x = F99F` at t+1; `result_valid`, `result_y = 1`, `result_pct = 92` at t+5 (SETTLE_CYC = 4); `infer_count = 1`.
- In SHOW, press `btn_label_x` with `result_y = 1` → one-cycle `nn_learn`, `nn_is_O = 0`, `learn_count = 1`, `correct_count = 0`. Then press `btn_label_o` on a following inference with `result_y = 1` → `correct_count = 1`.
- Press `btn_label_o` and `btn_label_x` in the same cycle, then hold submit 3 cycles → no learn strobe; a single re-inference only, one edge.
- HOLD_CYC = 20, no input after the result → `result_valid` falls exactly 20 cycles after it rose; state IDLE; label press afterwards ignored.
- Assert `rst` low during SETTLE and during LEARN → all outputs 0 asynchronously, `nn_learn` never stretched. Hold submit high through reset release → exactly one new inference.
- Drive 260 inferences with CNT_W = 8 → `infer_count` saturates at 255.

Source files
------------

// File: rtl/ox_pkg.sv
// Shared types and constants for the O/X inference/learning sequencer.
package ox_pkg;

    localparam int unsigned OX_X_W            = 16;
    localparam int unsigned OX_PCT_W          = 7;
    localparam int unsigned OX_SETTLE_CYC_DEF = 4;
    localparam int unsigned OX_HOLD_CYC_DEF   = 50_000_000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_SHOW,
        ST_LEARN,
        ST_COOL
    } ox_state_t;

    typedef struct packed {
        logic                y;
        logic [OX_PCT_W-1:0] pct;
    } ox_result_t;

    // Width of the shared down-counter: must hold both reload values, never zero bits.
    function automatic int unsigned ox_tmr_w(input int unsigned settle, input int unsigned hold);
        int unsigned w;
        w = ($clog2(hold) > $clog2(settle)) ? $clog2(hold) : $clog2(settle);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/ox_infer_seq_edge_det.sv
// Rising-edge detector; previous-value register clears on reset so a held level yields one edge.
module edge_det (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise_c
);

    logic prev;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) prev <= 1'b0;
        else      prev <= d;
    end

    assign rise_c = d & ~prev;

endmodule

// File: rtl/ox_infer_seq.sv
// Submit-driven inference/learning sequencer between the input manager and the O/X MLP.
module ox_infer_seq
    import ox_pkg::*;
#(
    parameter int unsigned SETTLE_CYC = OX_SETTLE_CYC_DEF,
    parameter int unsigned HOLD_CYC   = OX_HOLD_CYC_DEF,
    parameter int unsigned CNT_W      = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [OX_X_W-1:0]   x_in,
    input  logic                btn_submit,
    input  logic                btn_label_o,
    input  logic                btn_label_x,
    input  logic                nn_y,
    input  logic [OX_PCT_W-1:0] nn_o_prob_pct,
    output logic [OX_X_W-1:0]   nn_x,
    output logic                nn_learn,
    output logic                nn_is_O,
    output logic                result_valid,
    output logic                result_y,
    output logic [OX_PCT_W-1:0] result_pct,
    output logic                busy,
    output logic [CNT_W-1:0]    infer_count,
    output logic [CNT_W-1:0]    learn_count,
    output logic [CNT_W-1:0]    correct_count
);

    localparam int unsigned    TMR_W     = ox_tmr_w(SETTLE_CYC, HOLD_CYC);
    localparam logic [TMR_W-1:0] SETTLE_LD = TMR_W'(SETTLE_CYC - 1);
    localparam logic [TMR_W-1:0] HOLD_LD   = TMR_W'(HOLD_CYC - 1);

    logic             sub_e, lo_e, lx_e;
    ox_state_t        state, state_d;
    logic [TMR_W-1:0] cnt, cnt_d;
    logic [OX_X_W-1:0] nn_x_d;
    logic             nn_learn_d, nn_is_o_d, valid_d;
    ox_result_t       res, res_d, res_live;
    logic [CNT_W-1:0] infer_d, learn_d, correct_d;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    edge_det u_ed_submit (.clk(clk), .rst(rst), .d(btn_submit),  .rise_c(sub_e));
    edge_det u_ed_lbl_o  (.clk(clk), .rst(rst), .d(btn_label_o), .rise_c(lo_e));
    edge_det u_ed_lbl_x  (.clk(clk), .rst(rst), .d(btn_label_x), .rise_c(lx_e));

    assign res_live = {nn_y, nn_o_prob_pct};

    // Next-state and next-register values.
    always_comb begin
        state_d    = state;
        cnt_d      = cnt;
        nn_x_d     = nn_x;
        nn_learn_d = 1'b0;
        nn_is_o_d  = nn_is_O;
        valid_d    = result_valid;
        res_d      = res;
        infer_d    = infer_count;
        learn_d    = learn_count;
        correct_d  = correct_count;
        case (state)
            ST_IDLE: begin
                if (sub_e) begin
                    nn_x_d  = x_in;
                    cnt_d   = SETTLE_LD;
                    state_d = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (cnt == '0) begin
                    res_d   = res_live;
                    valid_d = 1'b1;
                    infer_d = sat_inc(infer_count);
                    cnt_d   = HOLD_LD;
                    state_d = ST_SHOW;
                end else begin
                    cnt_d = cnt - TMR_W'(1);
                end
            end
            ST_SHOW: begin
                cnt_d = cnt - TMR_W'(1);
                if (sub_e) begin
                    nn_x_d  = x_in;
                    valid_d = 1'b0;
                    cnt_d   = SETTLE_LD;
                    state_d = ST_SETTLE;
                end else if (lo_e ^ lx_e) begin
                    nn_is_o_d  = lo_e;
                    nn_learn_d = 1'b1;
                    learn_d    = sat_inc(learn_count);
                    if (res.y == lo_e) correct_d = sat_inc(correct_count);
                    state_d    = ST_LEARN;
                end else if (cnt == '0) begin
                    valid_d = 1'b0;
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end
            end
            ST_LEARN: begin
                cnt_d   = SETTLE_LD;
                state_d = ST_COOL;
            end
            ST_COOL: begin
                // Post-learn re-read of the MLP; not a new inference.
                if (cnt == '0) begin
                    res_d   = res_live;
                    cnt_d   = HOLD_LD;
                    state_d = ST_SHOW;
                end else begin
                    cnt_d = cnt - TMR_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= ST_IDLE;
            cnt           <= '0;
            nn_x          <= '0;
            nn_learn      <= 1'b0;
            nn_is_O       <= 1'b0;
            result_valid  <= 1'b0;
            res           <= '0;
            infer_count   <= '0;
            learn_count   <= '0;
            correct_count <= '0;
        end else begin
            state         <= state_d;
            cnt           <= cnt_d;
            nn_x          <= nn_x_d;
            nn_learn      <= nn_learn_d;
            nn_is_O       <= nn_is_o_d;
            result_valid  <= valid_d;
            res           <= res_d;
            infer_count   <= infer_d;
            learn_count   <= learn_d;
            correct_count <= correct_d;
        end
    end

    assign result_y   = res.y;
    assign result_pct = res.pct;
    assign busy       = (state == ST_SETTLE) || (state == ST_LEARN) || (state == ST_COOL);

endmodule

// File: tb/tb_ox_infer_seq.sv
// Directed bench for ox_infer_seq with SETTLE_CYC=4, HOLD_CYC=20, CNT_W=8.
module tb_ox_infer_seq;

    localparam int unsigned SETTLE = 4;
    localparam int unsigned HOLD   = 20;
    localparam int unsigned CW     = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [15:0]   x_in = '0;
    logic          btn_submit = 1'b0, btn_label_o = 1'b0, btn_label_x = 1'b0;
    logic          nn_y = 1'b0;
    logic [6:0]    nn_o_prob_pct = '0;
    logic [15:0]   nn_x;
    logic          nn_learn, nn_is_O, result_valid, result_y, busy;
    logic [6:0]    result_pct;
    logic [CW-1:0] infer_count, learn_count, correct_count;
    logic [51:0]   all_out;

    int errors = 0;
    int checks = 0;
    int learn_pulses = 0;

    ox_infer_seq #(.SETTLE_CYC(SETTLE), .HOLD_CYC(HOLD), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .x_in(x_in),
        .btn_submit(btn_submit), .btn_label_o(btn_label_o), .btn_label_x(btn_label_x),
        .nn_y(nn_y), .nn_o_prob_pct(nn_o_prob_pct),
        .nn_x(nn_x), .nn_learn(nn_learn), .nn_is_O(nn_is_O),
        .result_valid(result_valid), .result_y(result_y), .result_pct(result_pct),
        .busy(busy), .infer_count(infer_count), .learn_count(learn_count),
        .correct_count(correct_count)
    );

    always #5 clk = ~clk;

    assign all_out = {nn_x, nn_learn, nn_is_O, result_valid, result_y, result_pct, busy,
                      infer_count, learn_count, correct_count};

    always @(negedge clk) if (nn_learn === 1'b1) learn_pulses++;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic infer();
        btn_submit = 1'b1;
        tick(1);
        btn_submit = 1'b0;
        tick(SETTLE);
    endtask

    task automatic test_reset();
        #2 rst = 1'b0;
        #1;
        checks++; if (all_out !== 52'd0) begin errors++; $display("FAIL reset_outputs: got %h want 0", all_out); end
        tick(2);
        rst = 1'b1;
        tick(1);
        checks++; if (all_out !== 52'd0) begin errors++; $display("FAIL reset_idle: got %h want 0", all_out); end
    endtask

    task automatic test_infer();
        x_in = 16'hF99F; nn_y = 1'b1; nn_o_prob_pct = 7'd92;
        btn_submit = 1'b1;
        tick(1);
        btn_submit = 1'b0;
        checks++; if (nn_x !== 16'hF99F) begin errors++; $display("FAIL infer_nn_x: got %h want F99F", nn_x); end
        checks++; if ({busy, result_valid} !== 2'b10) begin errors++; $display("FAIL infer_busy_t1: got %b want 10", {busy, result_valid}); end
        x_in = 16'h1234;
        tick(SETTLE - 1);
        checks++; if ({busy, result_valid} !== 2'b10) begin errors++; $display("FAIL infer_not_yet: got %b want 10", {busy, result_valid}); end
        tick(1);
        checks++; if ({busy, result_valid, result_y} !== 3'b011) begin errors++; $display("FAIL infer_valid: got %b want 011", {busy, result_valid, result_y}); end
        checks++; if (result_pct !== 7'd92) begin errors++; $display("FAIL infer_pct: got %0d want 92", result_pct); end
        checks++; if (infer_count !== 8'd1) begin errors++; $display("FAIL infer_count: got %0d want 1", infer_count); end
        checks++; if (nn_x !== 16'hF99F) begin errors++; $display("FAIL infer_nn_x_hold: got %h want F99F", nn_x); end
    endtask

    task automatic test_learn();
        nn_o_prob_pct = 7'd80;
        btn_label_x = 1'b1;
        tick(1);
        btn_label_x = 1'b0;
        checks++; if ({nn_learn, nn_is_O, busy, result_valid} !== 4'b1011) begin errors++; $display("FAIL learn_strobe: got %b want 1011", {nn_learn, nn_is_O, busy, result_valid}); end
        checks++; if ({learn_count, correct_count} !== {8'd1, 8'd0}) begin errors++; $display("FAIL learn_counts_x: got %0d/%0d want 1/0", learn_count, correct_count); end
        tick(1);
        checks++; if ({nn_learn, result_valid, result_pct} !== {1'b0, 1'b1, 7'd92}) begin errors++; $display("FAIL learn_one_cycle: got %b/%b/%0d want 0/1/92", nn_learn, result_valid, result_pct); end
        tick(SETTLE - 1);
        checks++; if ({busy, result_pct} !== {1'b1, 7'd92}) begin errors++; $display("FAIL learn_cool_hold: got %b/%0d want 1/92", busy, result_pct); end
        tick(1);
        checks++; if ({busy, result_pct} !== {1'b0, 7'd80}) begin errors++; $display("FAIL learn_relatch: got %b/%0d want 0/80", busy, result_pct); end
        checks++; if ({infer_count, learn_pulses} !== {8'd1, 32'd1}) begin errors++; $display("FAIL learn_no_infer: got %0d/%0d want 1/1", infer_count, learn_pulses); end
        nn_o_prob_pct = 7'd70;
        infer();
        checks++; if (infer_count !== 8'd2) begin errors++; $display("FAIL learn_infer2: got %0d want 2", infer_count); end
        btn_label_o = 1'b1;
        tick(1);
        btn_label_o = 1'b0;
        checks++; if ({nn_learn, nn_is_O, learn_count, correct_count} !== {2'b11, 8'd2, 8'd1}) begin errors++; $display("FAIL learn_label_o: got %b%b %0d/%0d want 11 2/1", nn_learn, nn_is_O, learn_count, correct_count); end
        tick(SETTLE + 1);
        checks++; if ({busy, result_valid} !== 2'b01) begin errors++; $display("FAIL learn_back_show: got %b want 01", {busy, result_valid}); end
    endtask

    task automatic test_both_labels();
        btn_label_o = 1'b1; btn_label_x = 1'b1;
        tick(1);
        btn_label_o = 1'b0; btn_label_x = 1'b0;
        checks++; if ({nn_learn, busy, result_valid, learn_count} !== {3'b001, 8'd2}) begin errors++; $display("FAIL both_ignored: got %b%b%b %0d want 001 2", nn_learn, busy, result_valid, learn_count); end
        btn_submit = 1'b1;
        tick(1);
        checks++; if ({busy, result_valid} !== 2'b10) begin errors++; $display("FAIL both_resubmit: got %b want 10", {busy, result_valid}); end
        tick(2);
        btn_submit = 1'b0;
        tick(2);
        checks++; if ({result_valid, infer_count, learn_count} !== {1'b1, 8'd3, 8'd2}) begin errors++; $display("FAIL both_single_infer: got %b %0d/%0d want 1 3/2", result_valid, infer_count, learn_count); end
        tick(3);
        checks++; if ({result_valid, infer_count, learn_pulses} !== {1'b1, 8'd3, 32'd2}) begin errors++; $display("FAIL both_one_edge: got %b %0d/%0d want 1 3/2", result_valid, infer_count, learn_pulses); end
    endtask

    task automatic test_timeout();
        int n;
        infer();
        n = 0;
        while (result_valid === 1'b1 && n < 100) begin
            tick(1);
            n++;
        end
        checks++; if (n !== HOLD) begin errors++; $display("FAIL timeout_len: got %0d want %0d", n, HOLD); end
        checks++; if ({busy, result_valid, infer_count} !== {2'b00, 8'd4}) begin errors++; $display("FAIL timeout_idle: got %b%b %0d want 00 4", busy, result_valid, infer_count); end
        btn_label_o = 1'b1;
        tick(1);
        btn_label_o = 1'b0;
        tick(2);
        checks++; if ({nn_learn, busy, result_valid, learn_count} !== {3'b000, 8'd2}) begin errors++; $display("FAIL timeout_label_drop: got %b%b%b %0d want 000 2", nn_learn, busy, result_valid, learn_count); end
    endtask

    task automatic test_reset_learn();
        infer();
        btn_label_x = 1'b1;
        tick(1);
        btn_label_x = 1'b0;
        checks++; if (nn_learn !== 1'b1) begin errors++; $display("FAIL rstl_in_learn: got %b want 1", nn_learn); end
        #2 rst = 1'b0;
        #1;
        checks++; if (all_out !== 52'd0) begin errors++; $display("FAIL rstl_async: got %h want 0", all_out); end
        tick(1);
        rst = 1'b1;
        checks++; if (learn_pulses !== 2) begin errors++; $display("FAIL rstl_no_stretch: got %0d want 2", learn_pulses); end
    endtask

    task automatic test_reset_settle();
        btn_submit = 1'b1;
        tick(2);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rsts_in_settle: got %b want 1", busy); end
        rst = 1'b0;
        #1;
        checks++; if (all_out !== 52'd0) begin errors++; $display("FAIL rsts_async: got %h want 0", all_out); end
        tick(1);
        rst = 1'b1;
        tick(1);
        checks++; if ({busy, nn_x} !== {1'b1, 16'h1234}) begin errors++; $display("FAIL rsts_held_edge: got %b %h want 1 1234", busy, nn_x); end
        tick(SETTLE);
        checks++; if ({result_valid, infer_count} !== {1'b1, 8'd1}) begin errors++; $display("FAIL rsts_infer: got %b %0d want 1 1", result_valid, infer_count); end
        tick(HOLD + 3);
        checks++; if ({busy, result_valid, infer_count} !== {2'b00, 8'd1}) begin errors++; $display("FAIL rsts_one_only: got %b%b %0d want 00 1", busy, result_valid, infer_count); end
        btn_submit = 1'b0;
    endtask

    task automatic test_saturation();
        rst = 1'b0;
        #1;
        tick(1);
        rst = 1'b1;
        for (int i = 0; i < 260; i++) begin
            infer();
            if (i == 99) begin
                checks++; if (infer_count !== 8'd100) begin errors++; $display("FAIL sat_mid: got %0d want 100", infer_count); end
            end
        end
        checks++; if ({result_valid, infer_count} !== {1'b1, 8'd255}) begin errors++; $display("FAIL sat_end: got %b %0d want 1 255", result_valid, infer_count); end
    endtask

    initial begin
        test_reset();
        test_infer();
        test_learn();
        test_both_labels();
        test_timeout();
        test_reset_learn();
        test_reset_settle();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
